// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the EX/MEM boundary.
// Holds write-back select encodings and the default-width payload bundle.
package pipeline_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // Payload at default widths; the stage builds the same layout
  // from its own XLEN/REG_AW parameters.
  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic [1:0]            mem_reg_pc;
    logic                  mem_read;
    logic                  mem_write;
    logic                  jl;
    logic                  jlr;
    logic                  branch;
    logic                  zero;
    logic [XLEN_DEF-1:0]   pc_inc;
    logic [XLEN_DEF-1:0]   pc_plus_imm;
    logic [XLEN_DEF-1:0]   alu_out;
    logic [XLEN_DEF-1:0]   read_data_2;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_skid_slot.sv
// One pipeline slot: WIDTH-bit payload register plus valid bit.
// Ports: clk, reset (async low), load, clear (wins), d, q, valid.
module skid_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // clear drops only the valid bit; payload keeps its value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: valid/ready register with 1-entry skid, flush, gating
// and next-PC redirect. Ports: in_* from EX, out_* to MEM, fwd_*, redirect_*.
import pipeline_pkg::*;

module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_mem_reg_pc,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_jl,
  input  logic              in_jlr,
  input  logic              in_branch,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_pc_inc,
  input  logic [XLEN-1:0]   in_pc_plus_imm,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_read_data_2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic [1:0]        out_mem_reg_pc,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_jl,
  output logic              out_jlr,
  output logic              out_branch,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_pc_inc,
  output logic [XLEN-1:0]   out_pc_plus_imm,
  output logic [XLEN-1:0]   out_alu_out,
  output logic [XLEN-1:0]   out_read_data_2,
  output logic [REG_AW-1:0] fwd_rd,
  output logic              fwd_reg_write,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_target
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [1:0]        mem_reg_pc;
    logic              mem_read;
    logic              mem_write;
    logic              jl;
    logic              jlr;
    logic              branch;
    logic              zero;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   pc_plus_imm;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   read_data_2;
  } payload_t;

  localparam int W = $bits(payload_t);

  payload_t in_pl, main_d, main_q, skid_q;
  logic main_valid, skid_valid;
  logic xfer_in, drain;
  logic main_from_skid, main_from_in;
  logic main_load, main_clear;
  logic skid_load, skid_clear;

  always_comb begin
    in_pl             = '0;
    in_pl.rd          = in_rd;
    in_pl.reg_write   = in_reg_write;
    in_pl.mem_reg_pc  = in_mem_reg_pc;
    in_pl.mem_read    = in_mem_read;
    in_pl.mem_write   = in_mem_write;
    in_pl.jl          = in_jl;
    in_pl.jlr         = in_jlr;
    in_pl.branch      = in_branch;
    in_pl.zero        = in_zero;
    in_pl.pc_inc      = in_pc_inc;
    in_pl.pc_plus_imm = in_pc_plus_imm;
    in_pl.alu_out     = in_alu_out;
    in_pl.read_data_2 = in_read_data_2;
  end

  // Registered ready: a full skid is the only reason to refuse.
  assign in_ready = ~skid_valid;
  assign xfer_in  = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  assign main_from_skid = drain & skid_valid;
  assign main_from_in   = xfer_in & (~main_valid | drain);

  assign main_load  = ~flush & (main_from_skid | main_from_in);
  assign main_clear = flush | (drain & ~main_load);
  assign main_d     = skid_valid ? skid_q : in_pl;

  // Input arriving while main is stuck is the one in-flight transfer.
  assign skid_load  = ~flush & xfer_in & main_valid & ~drain;
  assign skid_clear = flush | main_from_skid;

  skid_slot #(.WIDTH(W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  skid_slot #(.WIDTH(W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pl),
    .q     (skid_q),
    .valid (skid_valid)
  );

  assign out_valid       = main_valid;
  assign out_rd          = main_q.rd;
  assign out_reg_write   = main_q.reg_write & main_valid;
  assign out_mem_reg_pc  = main_q.mem_reg_pc;
  assign out_mem_read    = main_q.mem_read & main_valid;
  assign out_mem_write   = main_q.mem_write & main_valid;
  assign out_jl          = main_q.jl & main_valid;
  assign out_jlr         = main_q.jlr & main_valid;
  assign out_branch      = main_q.branch & main_valid;
  assign out_zero        = main_q.zero;
  assign out_pc_inc      = main_q.pc_inc;
  assign out_pc_plus_imm = main_q.pc_plus_imm;
  assign out_alu_out     = main_q.alu_out;
  assign out_read_data_2 = main_q.read_data_2;

  assign fwd_rd        = main_q.rd;
  assign fwd_reg_write = out_reg_write;

  assign redirect_valid =
    out_jl | out_jlr | (out_branch & main_q.zero);
  assign redirect_target = main_q.jlr
    ? {main_q.alu_out[XLEN-1:1], 1'b0}
    : main_q.pc_plus_imm;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a 2-deep queue model.
// Directed cases cover reset, streaming, stall, flush and redirect.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  mem_reg_pc;
    logic        mem_read;
    logic        mem_write;
    logic        jl;
    logic        jlr;
    logic        branch;
    logic        zero;
    logic [31:0] pc_inc;
    logic [31:0] pc_plus_imm;
    logic [31:0] alu_out;
    logic [31:0] read_data_2;
  } pl_t;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  pl_t  cur;
  logic in_ready, out_valid;
  logic [4:0] out_rd, fwd_rd;
  logic out_reg_write, out_mem_read, out_mem_write;
  logic out_jl, out_jlr, out_branch, out_zero;
  logic [1:0] out_mem_reg_pc;
  logic [31:0] out_pc_inc, out_pc_plus_imm;
  logic [31:0] out_alu_out, out_read_data_2;
  logic fwd_reg_write, redirect_valid;
  logic [31:0] redirect_target;

  int checks = 0;
  int errors = 0;
  pl_t q[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(cur.rd), .in_reg_write(cur.reg_write),
    .in_mem_reg_pc(cur.mem_reg_pc),
    .in_mem_read(cur.mem_read), .in_mem_write(cur.mem_write),
    .in_jl(cur.jl), .in_jlr(cur.jlr),
    .in_branch(cur.branch), .in_zero(cur.zero),
    .in_pc_inc(cur.pc_inc), .in_pc_plus_imm(cur.pc_plus_imm),
    .in_alu_out(cur.alu_out), .in_read_data_2(cur.read_data_2),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_reg_pc(out_mem_reg_pc),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_jl(out_jl), .out_jlr(out_jlr),
    .out_branch(out_branch), .out_zero(out_zero),
    .out_pc_inc(out_pc_inc), .out_pc_plus_imm(out_pc_plus_imm),
    .out_alu_out(out_alu_out), .out_read_data_2(out_read_data_2),
    .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic pl_t rand_pl();
    pl_t p;
    p.rd          = 5'($urandom);
    p.reg_write   = 1'($urandom);
    p.mem_reg_pc  = 2'($urandom_range(0, 2));
    p.mem_read    = 1'($urandom);
    p.mem_write   = 1'($urandom);
    p.jl          = 1'($urandom);
    p.jlr         = 1'($urandom);
    p.branch      = 1'($urandom);
    p.zero        = 1'($urandom);
    p.pc_inc      = $urandom;
    p.pc_plus_imm = $urandom;
    p.alu_out     = $urandom;
    p.read_data_2 = $urandom;
    return p;
  endfunction

  // Compare every output against the head of the model queue.
  task automatic check_outputs();
    pl_t h;
    logic v;
    logic [5:0] ctl;
    logic [31:0] tgt;
    v = (q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, v);
    if (v) begin
      h = q[0];
      ctl = {h.reg_write, h.mem_read, h.mem_write,
             h.jl, h.jlr, h.branch};
      tgt = h.jlr ? (h.alu_out & 32'hFFFF_FFFE) : h.pc_plus_imm;
      check("rd", out_rd, h.rd);
      check("fwd_rd", fwd_rd, h.rd);
      check("wb_sel", out_mem_reg_pc, h.mem_reg_pc);
      check("zero", out_zero, h.zero);
      check("pc_inc", out_pc_inc, h.pc_inc);
      check("pc_imm", out_pc_plus_imm, h.pc_plus_imm);
      check("alu", out_alu_out, h.alu_out);
      check("rd2", out_read_data_2, h.read_data_2);
      check("redir_tgt", redirect_target, tgt);
    end else begin
      ctl = '0;
    end
    check("ctrl", {out_reg_write, out_mem_read, out_mem_write,
                   out_jl, out_jlr, out_branch}, ctl);
    check("fwd_we", fwd_reg_write, ctl[5]);
    check("redir_v", redirect_valid,
          v && (h.jl || h.jlr || (h.branch && h.zero)));
  endtask

  // One clock: model follows the handshake rules, then outputs checked.
  task automatic cycle();
    int n;
    @(posedge clk);
    n = q.size();
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back(cur);
    end
    #1 check_outputs();
  endtask

  task automatic send(input pl_t p);
    cur = p;
    in_valid = 1'b1;
    cycle();
  endtask

  initial begin
    pl_t p;
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cur = '0;
    cur.alu_out = 32'hDEAD_BEEF;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_alu", out_alu_out, 0);
    check("rst_rd", out_rd, 0);
    check("rst_ctrl", {out_reg_write, out_mem_read, out_mem_write,
                       out_jl, out_jlr, out_branch}, 0);
    check("rst_fwd", fwd_reg_write, 0);
    check("rst_redir", {redirect_valid, redirect_target}, 0);
    #5 reset = 1'b1;
    cycle();
    check("rel_alu", out_alu_out, 32'hDEAD_BEEF);

    // streaming rd=1..5
    for (int i = 1; i <= 5; i++) begin
      p = rand_pl();
      p.rd = 5'(i);
      send(p);
      check("stream_rd", out_rd, 5'(i));
    end
    in_valid = 1'b0;
    cycle();

    // stall: A held, B into skid
    out_ready = 1'b0;
    p = rand_pl(); p.rd = 5'd10; send(p);
    p = rand_pl(); p.rd = 5'd11; send(p);
    check("stall_ready", in_ready, 0);
    p = rand_pl(); p.rd = 5'd12; send(p);
    in_valid = 1'b0;
    cycle();
    check("stall_hold", out_rd, 5'd10);
    out_ready = 1'b1;
    cycle();
    check("drain_b", out_rd, 5'd11);
    cycle();
    check("drain_empty", out_valid, 0);

    // flush with store in main and skid full
    out_ready = 1'b0;
    p = rand_pl(); p.mem_write = 1'b1; send(p);
    send(rand_pl());
    flush = 1'b1;
    send(rand_pl());
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_store", out_mem_write, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1'b1;

    // branch taken / not taken
    p = rand_pl();
    {p.jl, p.jlr, p.branch, p.zero} = 4'b0011;
    p.pc_plus_imm = 32'h100;
    send(p);
    check("br_v", redirect_valid, 1);
    check("br_tgt", redirect_target, 32'h100);
    p.zero = 1'b0;
    send(p);
    check("br_nt", redirect_valid, 0);

    // jalr
    p = rand_pl();
    {p.jl, p.jlr, p.branch} = 3'b010;
    p.alu_out = 32'h203;
    p.reg_write = 1'b1;
    send(p);
    check("jlr_tgt", redirect_target, 32'h202);
    check("jlr_fwd", fwd_reg_write, 1);
    in_valid = 1'b0;
    cycle();
    check("fwd_idle", fwd_reg_write, 0);

    // reset asserted mid-stall
    out_ready = 1'b0;
    send(rand_pl());
    send(rand_pl());
    in_valid = 1'b0;
    #2 reset = 1'b0;
    q.delete();
    #1 check_outputs();
    check("mid_rst_alu", out_alu_out, 0);
    @(negedge clk);
    cycle();
    @(negedge clk) reset = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cur = rand_pl();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
